// File: rtl/xm_pkg.sv
// Purpose: shared types and constants for the controller / memory-interface slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xm_pkg;

  // Memory-interface FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Controller request encodings, shared so both sides agree on polarity.
  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_rw_e;

  typedef enum logic {
    ACC_WORD = 1'b0,
    ACC_BYTE = 1'b1
  } mem_size_e;

  // Byte enables: [1] = high byte, [0] = low byte.
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Read result returned when a read access is aborted.
  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/xm_byte_lane.sv
// Purpose: byte-lane steering -- byte enables, byte write replication, read lane extraction.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
// Ports: byte_op_i/lane_i/wr_data_i describe the incoming request (be_o, wr_data_o);
//        rd_be_i is the enable pattern of the access in flight, used to pick the read lane.
module xm_byte_lane
  import xm_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            byte_op_i,
  input  logic            lane_i,
  input  logic [WORD-1:0] wr_data_i,
  output logic [1:0]      be_o,
  output logic [WORD-1:0] wr_data_o,
  input  logic [1:0]      rd_be_i,
  input  logic [WORD-1:0] rd_data_i,
  output logic [WORD-1:0] rd_data_o
);

  always_comb begin
    be_o      = BE_WORD;
    wr_data_o = wr_data_i;
    if (byte_op_i) begin
      be_o      = lane_i ? BE_HI : BE_LO;
      // Put the byte on both lanes so the memory picks it up whichever lane is enabled.
      wr_data_o = {(WORD/8){wr_data_i[7:0]}};
    end
  end

  // The enable pattern already encodes word / low byte / high byte, so it selects the lane.
  always_comb begin
    rd_data_o = rd_data_i;
    if (rd_be_i == BE_HI) begin
      rd_data_o = {{(WORD-8){1'b0}}, rd_data_i[15:8]};
    end else if (rd_be_i == BE_LO) begin
      rd_data_o = {{(WORD-8){1'b0}}, rd_data_i[7:0]};
    end
  end

endmodule

// File: rtl/xm_mem_interface.sv
// Purpose: runs one req/ack memory bus transaction per controller request, with misalign and timeout errors.
// Latency: busy from the accepting edge until the edge ack is sampled (>= 1 busy cycle); timeout after TIMEOUT cycles.
// Backpressure: requests arriving while busy are dropped, not queued; the controller holds memEn_i into IDLE.
// Ports: controller side memEn_i/memRW_i/byteOp_i/adr_i/wrData_i -> memBusy_o/rdData_o/busErr_o;
//        bus side bus_req_o/bus_we_o/bus_adr_o/bus_be_o/bus_wdata_o -> bus_rdata_i/bus_ack_i.
module xm_mem_interface
  import xm_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic            memBusy_o,
  output logic [WORD-1:0] rdData_o,
  output logic            busErr_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [WORD-1:0] bus_adr_o,
  output logic [1:0]      bus_be_o,
  output logic [WORD-1:0] bus_wdata_o,
  input  logic [WORD-1:0] bus_rdata_i,
  input  logic            bus_ack_i
);

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_rw_e         rw_q;
  logic            busy_q, err_q, req_q, we_q;
  logic [WORD-1:0] adr_q, wdata_q, rdata_q;
  logic [1:0]      be_q;

  logic [1:0]      be_new;
  logic [WORD-1:0] wdata_new, rdata_lane;

  assign cnt_d = cnt_q + CNT_W'(1);

  xm_byte_lane #(.WORD(WORD)) u_byte_lane (
    .byte_op_i (byteOp_i),
    .lane_i    (adr_i[0]),
    .wr_data_i (wrData_i),
    .be_o      (be_new),
    .wr_data_o (wdata_new),
    .rd_be_i   (be_q),
    .rd_data_i (bus_rdata_i),
    .rd_data_o (rdata_lane)
  );

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= MEM_READ;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (memEn_i) begin
            rw_q   <= mem_rw_e'(memRW_i);
            busy_q <= 1'b1;
            if (byteOp_i == ACC_WORD && adr_i[0]) begin
              // Misaligned word: never reaches the bus.
              state_q <= ERR;
              err_q   <= 1'b1;
              if (memRW_i == MEM_READ) rdata_q <= WORD'(BUS_ERR_DATA);
            end else begin
              state_q <= REQ;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= memRW_i;
              adr_q   <= {adr_i[WORD-1:1], 1'b0};
              be_q    <= be_new;
              wdata_q <= wdata_new;
            end
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the timeout cycle still completes cleanly.
          if (bus_ack_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            if (rw_q == MEM_READ) rdata_q <= rdata_lane;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_q <= ERR;
            cnt_q   <= cnt_d;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            if (rw_q == MEM_READ) rdata_q <= WORD'(BUS_ERR_DATA);
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign memBusy_o   = busy_q;
  assign busErr_o    = err_q;
  assign rdData_o    = rdata_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_adr_o   = adr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_xm_mem_interface.sv
// Purpose: self-checking bench for xm_mem_interface against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_xm_mem_interface;

  localparam int WORD    = 16;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic        clk_i = 1'b0;
  logic        arst_i, memEn_i, memRW_i, byteOp_i, bus_ack_i;
  logic [15:0] adr_i, wrData_i, bus_rdata_i;
  logic        memBusy_o, busErr_o, bus_req_o, bus_we_o;
  logic [15:0] rdData_o, bus_adr_o, bus_wdata_o;
  logic [1:0]  bus_be_o;

  xm_mem_interface #(.WORD(WORD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .memEn_i     (memEn_i),
    .memRW_i     (memRW_i),
    .byteOp_i    (byteOp_i),
    .adr_i       (adr_i),
    .wrData_i    (wrData_i),
    .memBusy_o   (memBusy_o),
    .rdData_o    (rdData_o),
    .busErr_o    (busErr_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_adr_o   (bus_adr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Per-cycle expectations written by the driver, consumed by the compare process.
  logic        chk_en = 1'b0;
  logic        e_busy, e_req, e_err, e_rd_vld, e_we;
  logic [15:0] e_rd, e_adr, e_wdata;
  logic [1:0]  e_be;
  logic [15:0] rd_model;

  // Observations gathered per transaction for the literal checks.
  int          busy_cnt, req_cnt, err_cnt;
  logic [15:0] seen_adr, seen_wdata;
  logic [1:0]  seen_be;
  logic        seen_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("busy", {31'd0, memBusy_o}, {31'd0, e_busy});
      chk("req",  {31'd0, bus_req_o}, {31'd0, e_req});
      chk("err",  {31'd0, busErr_o},  {31'd0, e_err});
      if (e_rd_vld) chk("rdData", {16'd0, rdData_o}, {16'd0, e_rd});
      if (e_req) begin
        chk("bus_adr",   {16'd0, bus_adr_o},   {16'd0, e_adr});
        chk("bus_be",    {30'd0, bus_be_o},    {30'd0, e_be});
        chk("bus_wdata", {16'd0, bus_wdata_o}, {16'd0, e_wdata});
        chk("bus_we",    {31'd0, bus_we_o},    {31'd0, e_we});
      end
      if (memBusy_o) busy_cnt++;
      if (busErr_o)  err_cnt++;
      if (bus_req_o) begin
        req_cnt++;
        seen_adr   = bus_adr_o;
        seen_be    = bus_be_o;
        seen_wdata = bus_wdata_o;
        seen_we    = bus_we_o;
      end
    end
  end

  // One controller request. k = REQ cycle carrying the ack (1-based), 0 = never acked.
  // mid_en drives junk requests while busy (including the returning edge); late_ack pulses ack afterwards.
  task automatic run_txn(input logic rw, input logic byteop, input logic [15:0] adr,
                         input logic [15:0] wd, input logic [15:0] rd, input int k,
                         input logic mid_en, input logic late_ack);
    logic        misal;
    int          nreq, nbusy, errc;
    logic [15:0] lane, final_rd;
    misal = !byteop && adr[0];
    if (!byteop)     lane = rd;
    else if (adr[0]) lane = {8'h00, rd[15:8]};
    else             lane = {8'h00, rd[7:0]};
    if (misal) begin
      nreq = 0; nbusy = 1; errc = 1;
    end else if (k >= 1 && k <= TIMEOUT) begin
      nreq = k; nbusy = k; errc = 0;
    end else begin
      nreq = TIMEOUT; nbusy = TIMEOUT + 1; errc = TIMEOUT + 1;
    end
    if (rw)            final_rd = rd_model;
    else if (errc != 0) final_rd = 16'hFFFF;
    else               final_rd = lane;
    e_adr   = {adr[15:1], 1'b0};
    e_be    = !byteop ? 2'b11 : (adr[0] ? 2'b10 : 2'b01);
    e_wdata = byteop ? {wd[7:0], wd[7:0]} : wd;
    e_we    = rw;

    @(posedge clk_i); #1;
    busy_cnt = 0; req_cnt = 0; err_cnt = 0;
    memEn_i = 1'b1; memRW_i = rw; byteOp_i = byteop; adr_i = adr; wrData_i = wd;
    bus_rdata_i = rd; bus_ack_i = 1'b0;
    e_busy = 1'b0; e_req = 1'b0; e_err = 1'b0; e_rd_vld = 1'b1; e_rd = rd_model;

    for (int c = 1; c <= nbusy + 2; c++) begin
      @(posedge clk_i); #1;
      memEn_i = mid_en && c >= 2 && c <= nbusy;
      if (memEn_i) begin
        memRW_i = ~rw; byteOp_i = 1'b0; adr_i = 16'h0F0F; wrData_i = 16'hDEAD;
      end
      bus_ack_i = (!misal && k >= 1 && c == k) || (late_ack && c == nbusy + 1);
      if (late_ack && c == nbusy + 1) bus_rdata_i = 16'h1234;
      e_busy   = (c <= nbusy);
      e_req    = (c <= nreq);
      e_err    = (c == errc);
      e_rd_vld = (c != errc);
      e_rd     = (c > nbusy) ? final_rd : rd_model;
    end
    rd_model = final_rd;
  endtask

  initial begin
    arst_i = 1'b1; memEn_i = 1'b0; memRW_i = 1'b0; byteOp_i = 1'b0;
    adr_i = '0; wrData_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    rd_model = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy",  {31'd0, memBusy_o}, 32'd0);
    chk("rst_req",   {31'd0, bus_req_o}, 32'd0);
    chk("rst_err",   {31'd0, busErr_o},  32'd0);
    chk("rst_we",    {31'd0, bus_we_o},  32'd0);
    chk("rst_adr",   {16'd0, bus_adr_o}, 32'd0);
    chk("rst_be",    {30'd0, bus_be_o},  32'd0);
    chk("rst_wdata", {16'd0, bus_wdata_o}, 32'd0);
    chk("rst_rd",    {16'd0, rdData_o},  32'd0);
    arst_i = 1'b0;
    e_busy = 1'b0; e_req = 1'b0; e_err = 1'b0; e_rd_vld = 1'b1; e_rd = 16'h0000;
    e_we = 1'b0; e_adr = '0; e_be = '0; e_wdata = '0;
    chk_en = 1'b1;

    // Word read, ack in the 4th REQ cycle, with ignored requests while busy.
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 4, 1'b1, 1'b0);
    chk("t1_rd",   {16'd0, rdData_o}, 32'h0000BEEF);
    chk("t1_busy", busy_cnt, 32'd4);
    chk("t1_err",  err_cnt, 32'd0);
    chk("t1_adr",  {16'd0, seen_adr}, 32'h00000100);
    chk("t1_be",   {30'd0, seen_be}, 32'd3);

    // Byte write to the high lane, immediate ack.
    run_txn(1'b1, 1'b1, 16'h0201, 16'h12A5, 16'h0000, 1, 1'b0, 1'b0);
    chk("t2_adr",   {16'd0, seen_adr}, 32'h00000200);
    chk("t2_be",    {30'd0, seen_be}, 32'd2);
    chk("t2_wdata", {16'd0, seen_wdata}, 32'h0000A5A5);
    chk("t2_we",    {31'd0, seen_we}, 32'd1);
    chk("t2_busy",  busy_cnt, 32'd1);
    chk("t2_rd",    {16'd0, rdData_o}, 32'h0000BEEF);

    // Byte reads from each lane.
    run_txn(1'b0, 1'b1, 16'h0301, 16'h0000, 16'h7F80, 2, 1'b0, 1'b0);
    chk("t3_rd", {16'd0, rdData_o}, 32'h0000007F);
    run_txn(1'b0, 1'b1, 16'h0300, 16'h0000, 16'h7F80, 1, 1'b0, 1'b0);
    chk("t4_rd", {16'd0, rdData_o}, 32'h00000080);

    // Misaligned word read.
    run_txn(1'b0, 1'b0, 16'h0011, 16'h0000, 16'h5555, 0, 1'b0, 1'b0);
    chk("t5_req",  req_cnt, 32'd0);
    chk("t5_err",  err_cnt, 32'd1);
    chk("t5_busy", busy_cnt, 32'd1);
    chk("t5_rd",   {16'd0, rdData_o}, 32'h0000FFFF);

    // Good word read, then a read that times out followed by a stray ack.
    run_txn(1'b0, 1'b0, 16'h0222, 16'h0000, 16'h1357, 2, 1'b0, 1'b0);
    chk("t6_rd", {16'd0, rdData_o}, 32'h00001357);
    run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h9999, 0, 1'b0, 1'b1);
    chk("t7_req",  req_cnt, 32'd15);
    chk("t7_busy", busy_cnt, 32'd16);
    chk("t7_err",  err_cnt, 32'd1);
    chk("t7_rd",   {16'd0, rdData_o}, 32'h0000FFFF);

    // Ack on the cycle the timeout would fire: completes without error.
    run_txn(1'b0, 1'b0, 16'h0500, 16'h0000, 16'h2468, 15, 1'b0, 1'b0);
    chk("t8_err",  err_cnt, 32'd0);
    chk("t8_busy", busy_cnt, 32'd15);
    chk("t8_rd",   {16'd0, rdData_o}, 32'h00002468);

    // Misaligned word write leaves the read result alone.
    run_txn(1'b1, 1'b0, 16'h0013, 16'hCAFE, 16'h0000, 0, 1'b0, 1'b0);
    chk("t9_err", err_cnt, 32'd1);
    chk("t9_rd",  {16'd0, rdData_o}, 32'h00002468);

    // Reset in the 2nd REQ cycle, then a late ack.
    chk_en = 1'b0;
    @(posedge clk_i); #1;
    memEn_i = 1'b1; memRW_i = 1'b0; byteOp_i = 1'b0; adr_i = 16'h0400; bus_rdata_i = 16'hABCD;
    @(posedge clk_i); #1;
    memEn_i = 1'b0;
    @(posedge clk_i); #1;
    chk("r_req_before", {31'd0, bus_req_o}, 32'd1);
    arst_i = 1'b1;
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    chk("r_req",  {31'd0, bus_req_o}, 32'd0);
    chk("r_busy", {31'd0, memBusy_o}, 32'd0);
    chk("r_rd",   {16'd0, rdData_o},  32'd0);
    bus_ack_i = 1'b1;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    chk("r_ack_busy", {31'd0, memBusy_o}, 32'd0);
    chk("r_ack_req",  {31'd0, bus_req_o}, 32'd0);
    chk("r_ack_rd",   {16'd0, rdData_o},  32'd0);
    chk("r_ack_err",  {31'd0, busErr_o},  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
